avmm_slave_arbiter: RTL and testbench
=====================================

Name: avmm_slave_arbiter

Overview:
Two-master round-robin arbiter that shares the single Avalon-MM slave port of program_logic (s0_*) between a host command path (m0, the UART bridge) and a second requester (m1, e.g. a local debug/scan engine). It arbitrates, forwards the granted master's address, strobes and write data to the slave, and returns readdata/waitrequest to the granted master only. It sits between the UART bridge logic and program_logic in the harness.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, read/write data width
TIMEOUT_CYCLES, 1024, consecutive stalled granted cycles before forced completion (only used with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_address  in  ADDR_WIDTH  master 0 address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_WIDTH  master 0 write data
m0_readdata  out  DATA_WIDTH  master 0 read data
m0_waitrequest  out  1  master 0 stall
m0_error  out  1  master 0 timeout completion pulse
m1_address, m1_read, m1_write, m1_writedata, m1_readdata, m1_waitrequest, m1_error: same as m0, for master 1
s0_address  out  ADDR_WIDTH  to slave
s0_read  out  1  to slave
s0_write  out  1  to slave
s0_writedata  out  DATA_WIDTH  to slave
s0_readdata  in  DATA_WIDTH  from slave
s0_waitrequest  in  1  from slave
grant  out  2  one-hot current grant (00 when idle)

Behaviour:
- Clock clk; reset synchronous, active-high, sampled on rising clk edge only.
- Request: mN_req = mN_read | mN_write. Masters hold strobes, address and writedata stable until their waitrequest is low.
- States: IDLE, GNT0, GNT1. Reset -> IDLE, last-served pointer = 1 (m0 wins first tie).
- IDLE: no requests -> stay. One request -> GNTn. Both -> master not equal to last-served. Grant registered: 1-cycle arbitration latency; a master's earliest completion is the 2nd cycle after it asserts request.
- GNTn: s0_address/read/write/writedata = mN's, combinationally; mN_waitrequest = s0_waitrequest; mN_readdata = s0_readdata (valid in the cycle waitrequest is low).
- Completion in GNTn: mN_req & ~s0_waitrequest. Next state: GNT(other) if other master requesting, else IDLE; last-served <= n.
- mN drops request while granted (protocol violation): no completion, last-served unchanged, next state IDLE; slave strobes follow the master (deasserted).
- Non-granted master: waitrequest = 1, readdata = 0, error = 0. In IDLE: both waitrequests 1, s0_read = s0_write = 0, s0_address/writedata = 0.
- read & write both asserted: forwarded unchanged; arbiter does not filter.
- Reset outputs: grant = 00, s0_read = s0_write = 0, m0/m1_waitrequest = 1, m*_readdata = 0, m*_error = 0. Reset mid-transaction aborts it; slave strobes drop in the cycle after reset is sampled.
- No starvation: with both masters continuously requesting, grants strictly alternate.

Optional Feature:
ARB_TIMEOUT_EN. Defined: 32-bit stall counter, cleared on grant change and completion, increments each GNTn cycle with s0_waitrequest high. When counter == TIMEOUT_CYCLES, the next cycle is a forced completion: s0_read = s0_write = 0, mN_waitrequest = 0, mN_readdata = all ones, mN_error = 1 for one cycle; state advances as for normal completion. Undefined: no counter, m0_error = m1_error = 0 constant, arbiter waits indefinitely.

Test Plan:
- Reset, then m0 read addr 0x10, slave waitrequest low with readdata 0xCAFEF00D -> grant=01 one cycle after request, m0_readdata=0xCAFEF00D, m0_waitrequest low that cycle, m1_waitrequest stays 1.
- m0 and m1 both request from same cycle, held continuously -> grants 01,10,01,10 on successive completions; first grant m0.
- m1 write 0x4 data 0x12345678, slave stalls 3 cycles -> s0_write/address/writedata stable 4 cycles, m1_waitrequest high 3 then low 1 cycle, single write seen by slave.
- m0 granted, reset asserted while slave stalls -> next cycle grant=00, s0_read=0, m0_waitrequest=1; post-reset m0 re-request is granted first.
- m1 granted, drops m1_read before completion -> next cycle IDLE, pending m0 granted the cycle after, last-served unchanged (tie then goes to m1 again).
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave holds waitrequest high -> after 8 stalled cycles one cycle with m0_waitrequest=0, m0_readdata=0xFFFFFFFF, m0_error=1, s0_read=0; without macro, m0 still stalled at cycle 100.

Source files
------------

// File: rtl/avmm_slave_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-MM slave port.
//
// m0 (host/UART bridge) and m1 (local requester) share slave port s0. The grant is
// registered, so a request is arbitrated in the cycle it appears and forwarded from
// the next cycle on. While a master is granted, its address, strobes and write data
// drive s0 combinationally. s0 readdata and waitrequest are returned only to that
// master. The master that is not granted sees waitrequest = 1, readdata = 0 and
// error = 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   m0_* / m1_*                master ports (address, read, write, writedata in;
//                              readdata, waitrequest, error out)
//   s0_*                       slave port (address, read, write, writedata out;
//                              readdata, waitrequest in)
//   grant                      one-hot current grant, 00 when idle
//
// Build option: define ARB_TIMEOUT_EN to force-complete a granted transfer after
// TIMEOUT_CYCLES consecutive stalled cycles. A forced completion returns all-ones
// read data and pulses mN_error. Without the macro the arbiter waits indefinitely
// and both error outputs stay 0.

module avmm_slave_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_waitrequest,
  output logic                  m0_error,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_waitrequest,
  output logic                  m1_error,
  output logic [ADDR_WIDTH-1:0] s0_address,
  output logic                  s0_read,
  output logic                  s0_write,
  output logic [DATA_WIDTH-1:0] s0_writedata,
  input  logic [DATA_WIDTH-1:0] s0_readdata,
  input  logic                  s0_waitrequest,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;   // index of the master served last
  logic   m0_req, m1_req;
  logic   req_g;            // granted master is still requesting
  logic   forced;           // timeout completion this cycle
  logic   done;             // transfer completes this cycle

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  always_comb begin
    req_g = 1'b0;
    unique case (state_q)
      StGnt0:  req_g = m0_req;
      StGnt1:  req_g = m1_req;
      default: req_g = 1'b0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [31:0] stall_q, stall_d;

  assign forced = req_g && (stall_q == 32'(TIMEOUT_CYCLES));

  // Remaining in the same grant state implies the slave stalled this cycle
  // (otherwise it would have completed), so no separate waitrequest test is needed.
  always_comb begin
    stall_d = '0;
    if ((state_q != StIdle) && (state_d == state_q)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_timeout;

  assign forced         = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  assign done = req_g & (~s0_waitrequest | forced);

  // Next-state: round-robin on ties, hand straight over to a waiting master on
  // completion, and fall back to idle if the granted master abandons its request.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
          state_d = last_q ? StGnt0 : StGnt1;
        end else if (m0_req) begin
          state_d = StGnt0;
        end else if (m1_req) begin
          state_d = StGnt1;
        end
      end
      StGnt0: begin
        if (!m0_req) begin
          state_d = StIdle;
        end else if (done) begin
          state_d = m1_req ? StGnt1 : StIdle;
          last_d  = 1'b0;
        end
      end
      StGnt1: begin
        if (!m1_req) begin
          state_d = StIdle;
        end else if (done) begin
          state_d = m0_req ? StGnt0 : StIdle;
          last_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Datapath muxing; a forced completion suppresses the slave strobes.
  always_comb begin
    s0_address     = '0;
    s0_read        = 1'b0;
    s0_write       = 1'b0;
    s0_writedata   = '0;
    m0_readdata    = '0;
    m0_waitrequest = 1'b1;
    m0_error       = 1'b0;
    m1_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_error       = 1'b0;
    unique case (state_q)
      StGnt0: begin
        s0_address     = m0_address;
        s0_read        = m0_read & ~forced;
        s0_write       = m0_write & ~forced;
        s0_writedata   = m0_writedata;
        m0_waitrequest = s0_waitrequest & ~forced;
        m0_readdata    = forced ? '1 : s0_readdata;
        m0_error       = forced;
      end
      StGnt1: begin
        s0_address     = m1_address;
        s0_read        = m1_read & ~forced;
        s0_write       = m1_write & ~forced;
        s0_writedata   = m1_writedata;
        m1_waitrequest = s0_waitrequest & ~forced;
        m1_readdata    = forced ? '1 : s0_readdata;
        m1_error       = forced;
      end
      default: ;
    endcase
  end

  assign grant = {state_q == StGnt1, state_q == StGnt0};

endmodule

// File: tb/tb_avmm_slave_arbiter.sv
`timescale 1ns/1ps
module tb_avmm_slave_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int unsigned TO = 8;
  localparam int NTXN = 200;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] m0_address, m1_address, s0_address;
  logic m0_read, m0_write, m1_read, m1_write, s0_read, s0_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s0_writedata;
  logic [DW-1:0] m0_readdata, m1_readdata, s0_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_error, m1_error, s0_waitrequest;
  logic [1:0] grant;

  avmm_slave_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_waitrequest(m0_waitrequest), .m0_error(m0_error),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_waitrequest(m1_waitrequest), .m1_error(m1_error),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_readdata(s0_readdata),
    .s0_waitrequest(s0_waitrequest), .grant(grant)
  );

  always #5 clk = ~clk;

  // Slave memory model: 32 words, combinational read.
  logic [DW-1:0] slave_mem [32];
  assign s0_readdata = slave_mem[s0_address[4:0]];

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t mq0[$], mq1[$], sq0[$], sq1[$];
  logic [DW-1:0] ref_mem [32];
  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0;
  bit mon_on = 0, sb_on = 0;

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'hCAFE_F00D;
    return 32'hA000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input int n, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic launch(input int n);
    txn_t t;
    int idx;
    idx = n * 16 + int'($urandom_range(0, 15));
    t.wr = 1'($urandom_range(0, 1));
    t.addr = 32'(idx);
    t.wdata = $urandom;
    t.rdata = t.wr ? 32'h0 : ref_mem[idx];
    if (t.wr) ref_mem[idx] = t.wdata;
    if (n == 0) begin mq0.push_back(t); sq0.push_back(t); end
    else begin mq1.push_back(t); sq1.push_back(t); end
    drv(n, !t.wr, t.wr, t.addr, t.wdata);
  endtask

  // Monitor: invariants every cycle, scoreboard pops on completions.
  initial begin
    txn_t t;
    int skip0, skip1;
    bit c0, c1;
    skip0 = 0;
    skip1 = 0;
    for (int i = 0; i < 32; i++) slave_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("grant onehot0", 64'(grant == 2'b11), 0);
        if (!grant[0]) chk("m0 idle outputs", {m0_waitrequest, m0_readdata, m0_error},
                           {1'b1, 32'h0, 1'b0});
        if (!grant[1]) chk("m1 idle outputs", {m1_waitrequest, m1_readdata, m1_error},
                           {1'b1, 32'h0, 1'b0});
        if (grant == 2'b00) chk("s0 idle outputs", {s0_read, s0_write, s0_address, s0_writedata},
                                66'h0);
      end
      if (s0_write && !s0_waitrequest) begin
        slave_mem[s0_address[4:0]] = s0_writedata;
        wr_cnt++;
      end
      if (sb_on) begin
        if ((s0_read || s0_write) && !s0_waitrequest) begin
          if (grant == 2'b10) begin
            chk("slave txn expected m1", 64'(sq1.size() != 0), 1);
            if (sq1.size() != 0) begin
              t = sq1.pop_front();
              chk("slave m1 access", {s0_read, s0_write, s0_address, s0_writedata},
                  {!t.wr, t.wr, t.addr, t.wdata});
            end
          end else begin
            chk("slave txn expected m0", 64'(sq0.size() != 0), 1);
            if (sq0.size() != 0) begin
              t = sq0.pop_front();
              chk("slave m0 access", {s0_read, s0_write, s0_address, s0_writedata},
                  {!t.wr, t.wr, t.addr, t.wdata});
            end
          end
        end
        c0 = (m0_read || m0_write) && !m0_waitrequest;
        c1 = (m1_read || m1_write) && !m1_waitrequest;
        if (c0) begin
          skip0 = 0;
          chk("m0 txn expected", 64'(mq0.size() != 0), 1);
          if (mq0.size() != 0) begin
            t = mq0.pop_front();
            if (!t.wr) chk("m0 readdata", m0_readdata, t.rdata);
          end
          if (m1_read || m1_write) begin
            skip1++;
            chk("m1 starvation bound", 64'(skip1 <= 1), 1);
          end
        end
        if (c1) begin
          skip1 = 0;
          chk("m1 txn expected", 64'(mq1.size() != 0), 1);
          if (mq1.size() != 0) begin
            t = mq1.pop_front();
            if (!t.wr) chk("m1 readdata", m1_readdata, t.rdata);
          end
          if (m0_read || m0_write) begin
            skip0++;
            chk("m0 starvation bound", 64'(skip0 <= 1), 1);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [1:0] t2_exp [5];
    int wr0, issued0, issued1, stall_run;
    bit d0, d1, err_seen;
    t2_exp = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    reset = 1'b1;
    s0_waitrequest = 1'b1;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    step();
    step();
    mon_on = 1;
    smp();
    chk("reset grant", grant, 2'b00);
    chk("reset waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
    chk("reset strobes", {s0_read, s0_write}, 2'b00);
    chk("reset errors", {m0_error, m1_error}, 2'b00);

    // Single read, zero-wait slave
    do_reset();
    s0_waitrequest = 1'b0;
    drv(0, 1, 0, 32'h10, 0);
    smp();
    chk("t1 arb cycle grant", grant, 2'b00);
    chk("t1 arb cycle m0 wait", m0_waitrequest, 1);
    step();
    smp();
    chk("t1 grant", grant, 2'b01);
    chk("t1 m0 wait", m0_waitrequest, 0);
    chk("t1 m0 readdata", m0_readdata, 32'hCAFE_F00D);
    chk("t1 m1 wait", m1_waitrequest, 1);
    chk("t1 s0 read/addr", {s0_read, s0_address}, {1'b1, 32'h10});
    step();
    drv(0, 0, 0, 0, 0);
    smp();
    chk("t1 back to idle", grant, 2'b00);

    // Both masters continuously requesting
    do_reset();
    s0_waitrequest = 1'b0;
    drv(0, 1, 0, 32'h1, 0);
    drv(1, 1, 0, 32'h11, 0);
    for (int i = 0; i < 5; i++) begin
      smp();
      chk($sformatf("t2 grant seq %0d", i), grant, t2_exp[i]);
      step();
    end
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);

    // m1 write with three stall cycles
    do_reset();
    s0_waitrequest = 1'b1;
    wr0 = wr_cnt;
    drv(1, 0, 1, 32'h4, 32'h1234_5678);
    smp();
    step();
    for (int i = 0; i < 4; i++) begin
      s0_waitrequest = (i < 3);
      smp();
      chk($sformatf("t3 s0 write %0d", i), {s0_write, s0_address, s0_writedata},
          {1'b1, 32'h4, 32'h1234_5678});
      chk($sformatf("t3 m1 wait %0d", i), m1_waitrequest, 64'(i < 3));
      step();
    end
    drv(1, 0, 0, 0, 0);
    smp();
    chk("t3 single slave write", 64'(wr_cnt - wr0), 1);
    chk("t3 slave mem", slave_mem[4], 32'h1234_5678);
    ref_mem[4] = 32'h1234_5678;

    // Reset while granted and stalled
    do_reset();
    s0_waitrequest = 1'b1;
    drv(0, 1, 0, 32'h2, 0);
    smp();
    step();
    smp();
    chk("t4 granted", grant, 2'b01);
    step();
    reset = 1'b1;
    step();
    smp();
    chk("t4 reset abort", {grant, s0_read, m0_waitrequest}, {2'b00, 1'b0, 1'b1});
    step();
    reset = 1'b0;
    drv(1, 1, 0, 32'h12, 0);
    smp();
    step();
    smp();
    chk("t4 m0 first after reset", grant, 2'b01);
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);

    // Granted master abandons its request; v=1 re-raises m1 to probe last-served
    for (int v = 0; v < 2; v++) begin
      do_reset();
      s0_waitrequest = 1'b0;
      drv(0, 1, 0, 32'h3, 0);
      step();
      step();
      drv(0, 0, 0, 0, 0);
      s0_waitrequest = 1'b1;
      drv(1, 1, 0, 32'h13, 0);
      step();
      drv(0, 1, 0, 32'h6, 0);
      step();
      drv(1, 0, 0, 0, 0);
      smp();
      chk($sformatf("t5.%0d m1 still granted", v), {grant, s0_read}, {2'b10, 1'b0});
      step();
      if (v == 1) drv(1, 1, 0, 32'h13, 0);
      smp();
      chk($sformatf("t5.%0d drop to idle", v), grant, 2'b00);
      step();
      smp();
      chk($sformatf("t5.%0d next grant", v), grant, (v == 0) ? 2'b01 : 2'b10);
      drv(0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0);
    end

    // Stalling slave
    do_reset();
    s0_waitrequest = 1'b1;
    drv(0, 1, 0, 32'h5, 0);
    err_seen = 0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i <= int'(TO); i++) begin
      step();
      smp();
      if (i < int'(TO)) begin
        chk($sformatf("t6 stalled %0d", i), {m0_waitrequest, m0_error}, 2'b10);
      end else begin
        chk("t6 forced completion", {m0_waitrequest, m0_readdata, m0_error, s0_read},
            {1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
      end
    end
    step();
    drv(0, 0, 0, 0, 0);
    smp();
    chk("t6 error pulse ends", m0_error, 0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      smp();
      err_seen |= m0_error;
    end
    chk("t6 still stalled", {grant, m0_waitrequest}, {2'b01, 1'b1});
    chk("t6 no error", 64'(err_seen), 0);
    drv(0, 0, 0, 0, 0);
`endif

    // Randomised traffic against the scoreboard
    do_reset();
    s0_waitrequest = 1'b0;
    sb_on = 1;
    issued0 = 0;
    issued1 = 0;
    stall_run = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      smp();
      d0 = (m0_read || m0_write) && !m0_waitrequest;
      d1 = (m1_read || m1_write) && !m1_waitrequest;
      if (issued0 >= NTXN && issued1 >= NTXN && mq0.size() == 0 && mq1.size() == 0 &&
          !(m0_read || m0_write || m1_read || m1_write)) break;
      step();
      if (d0) drv(0, 0, 0, 0, 0);
      if (d1) drv(1, 0, 0, 0, 0);
      if (!(m0_read || m0_write) && issued0 < NTXN && $urandom_range(0, 1) == 1) begin
        launch(0);
        issued0++;
      end
      if (!(m1_read || m1_write) && issued1 < NTXN && $urandom_range(0, 1) == 1) begin
        launch(1);
        issued1++;
      end
      s0_waitrequest = (stall_run < 3) && ($urandom_range(0, 3) == 0);
      stall_run = s0_waitrequest ? stall_run + 1 : 0;
    end
    chk("random all m0 issued", 64'(issued0), NTXN);
    chk("random all m1 issued", 64'(issued1), NTXN);
    chk("random m0 queues drained", 64'(mq0.size() + sq0.size()), 0);
    chk("random m1 queues drained", 64'(mq1.size() + sq1.size()), 0);
    sb_on = 0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
